// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit_if
// Description : Request/response bundle between the register-read stage and
//               the ALU execution unit. The requester drives the operation
//               and operands; the unit returns decode, result and HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALUOp;
    logic [5:0]       ALUFunction;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   shamt;
    logic [3:0]       ALUOperation;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, ALUOp, ALUFunction, A, B, shamt,
        input  in_ready, ALUOperation, out_valid, result, zero, err, hi, lo
    );

    modport slave (
        input  in_valid, ALUOp, ALUFunction, A, B, shamt,
        output in_ready, ALUOperation, out_valid, result, zero, err, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : MIPS ALU execution unit. Decodes ALUOp/ALUFunction, executes
//               single-cycle operations with a registered result, and runs
//               unsigned multiply/divide iteratively into HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic       clk,
    input  wire logic       reset,
    alu_exec_unit_if.slave  bus
);

    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_NOR   = 4'b0010;
    localparam logic [3:0] c_OP_ADD   = 4'b0011;
    localparam logic [3:0] c_OP_SUB   = 4'b0100;
    localparam logic [3:0] c_OP_SLL   = 4'b0101;
    localparam logic [3:0] c_OP_SRL   = 4'b0110;
    localparam logic [3:0] c_OP_LUI   = 4'b0111;
    localparam logic [3:0] c_OP_INV   = 4'b1001;
    localparam logic [3:0] c_OP_MULTU = 4'b1010;
    localparam logic [3:0] c_OP_DIVU  = 4'b1011;
    localparam logic [3:0] c_OP_MFHI  = 4'b1100;
    localparam logic [3:0] c_OP_MFLO  = 4'b1101;

    localparam logic [SHW:0] c_CNT_ONE  = (SHW+1)'(1);
    localparam logic [SHW:0] c_CNT_DONE = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t             r_state;
    logic [SHW:0]       r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_err;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [3:0]         w_op;
    logic               w_ready;
    logic               w_accept;
    logic [WIDTH-1:0]   w_sc_result;
    logic               w_sc_err;
    logic               w_sc_wr_hilo;
    logic [WIDTH-1:0]   w_sc_hi;
    logic [WIDTH-1:0]   w_sc_lo;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;
    logic [SHW:0]       w_cnt_next;
    logic               w_last;

    assign w_ready  = (r_state == IDLE);
    assign w_accept = bus.in_valid && w_ready;

    assign bus.in_ready     = w_ready;
    assign bus.ALUOperation = w_op;
    assign bus.out_valid    = r_out_valid;
    assign bus.result       = r_result;
    assign bus.zero         = r_zero;
    assign bus.err          = r_err;
    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;

    // Decode the operation class and function field into the ALU operation code.
    always_comb begin
        w_op = c_OP_INV;
        casez ({bus.ALUOp, bus.ALUFunction})
            9'b111_100100: w_op = c_OP_AND;
            9'b111_100101: w_op = c_OP_OR;
            9'b111_100111: w_op = c_OP_NOR;
            9'b111_100000: w_op = c_OP_ADD;
            9'b111_100010: w_op = c_OP_SUB;
            9'b111_000000: w_op = c_OP_SLL;
            9'b111_000010: w_op = c_OP_SRL;
            9'b111_011001: w_op = c_OP_MULTU;
            9'b111_011011: w_op = c_OP_DIVU;
            9'b111_010000: w_op = c_OP_MFHI;
            9'b111_010010: w_op = c_OP_MFLO;
            9'b100_??????: w_op = c_OP_ADD;
            9'b101_??????: w_op = c_OP_OR;
            9'b110_??????: w_op = c_OP_AND;
            9'b001_??????: w_op = c_OP_LUI;
            9'b010_??????: w_op = c_OP_ADD;
            default:       w_op = c_OP_INV;
        endcase
    end

    // Results of every operation that completes in the accept cycle.
    always_comb begin
        w_sc_result  = '0;
        w_sc_err     = 1'b0;
        w_sc_wr_hilo = 1'b0;
        w_sc_hi      = r_hi;
        w_sc_lo      = r_lo;
        case (w_op)
            c_OP_AND:   w_sc_result = bus.A & bus.B;
            c_OP_OR:    w_sc_result = bus.A | bus.B;
            c_OP_NOR:   w_sc_result = ~(bus.A | bus.B);
            c_OP_ADD:   w_sc_result = bus.A + bus.B;
            c_OP_SUB:   w_sc_result = bus.A - bus.B;
            c_OP_SLL:   w_sc_result = bus.B << bus.shamt;
            c_OP_SRL:   w_sc_result = bus.B >> bus.shamt;
            c_OP_LUI:   w_sc_result = {bus.B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            c_OP_MFHI:  w_sc_result = r_hi;
            c_OP_MFLO:  w_sc_result = r_lo;
            c_OP_MULTU: w_sc_result = '0;
            // Only the divide-by-zero case finishes here: saturated quotient, dividend as remainder.
            c_OP_DIVU: begin
                w_sc_result  = '1;
                w_sc_wr_hilo = 1'b1;
                w_sc_hi      = bus.A;
                w_sc_lo      = '1;
            end
            default:    w_sc_err = 1'b1;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide, plus the shared counter.
    always_comb begin
        w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};
        w_rem_sh    = {r_rem, r_quot[WIDTH-1]};
        w_rem_ge    = (w_rem_sh >= {1'b0, r_dvsr});
        w_rem_next  = w_rem_ge ? (w_rem_sh[WIDTH-1:0] - r_dvsr) : w_rem_sh[WIDTH-1:0];
        w_quot_next = {r_quot[WIDTH-2:0], w_rem_ge};
        w_cnt_next  = r_cnt + c_CNT_ONE;
        w_last      = (w_cnt_next == c_CNT_DONE);
    end

    // Control FSM with registered result, flags and HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_prod      <= '0;
            r_mcand     <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_dvsr      <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_op == c_OP_MULTU) begin
                            r_state <= MUL;
                            r_cnt   <= '0;
                            r_prod  <= {{WIDTH{1'b0}}, bus.B};
                            r_mcand <= bus.A;
                        end else if ((w_op == c_OP_DIVU) && (bus.B != '0)) begin
                            r_state <= DIV;
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            r_quot  <= bus.A;
                            r_dvsr  <= bus.B;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_sc_result;
                            r_zero      <= (w_sc_result == '0);
                            r_err       <= w_sc_err;
                            if (w_sc_wr_hilo) begin
                                r_hi <= w_sc_hi;
                                r_lo <= w_sc_lo;
                            end
                        end
                    end
                end
                MUL: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= w_cnt_next;
                    if (w_last) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_hi        <= w_prod_next[2*WIDTH-1:WIDTH];
                        r_lo        <= w_prod_next[WIDTH-1:0];
                        r_result    <= w_prod_next[WIDTH-1:0];
                        r_zero      <= (w_prod_next[WIDTH-1:0] == '0);
                        r_err       <= 1'b0;
                    end
                end
                DIV: begin
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next;
                    r_cnt  <= w_cnt_next;
                    if (w_last) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_hi        <= w_rem_next;
                        r_lo        <= w_quot_next;
                        r_result    <= w_quot_next;
                        r_zero      <= (w_quot_next == '0);
                        r_err       <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit: decode sweep, directed
//               corner cases, handshake/reset behaviour and random operations
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // Reference HI/LO contents
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Selector {ALUOp,ALUFunction} and its operation code
    logic [8:0] t_sel [0:18] = '{
        9'b111_100100, 9'b111_100101, 9'b111_100111, 9'b111_100000,
        9'b111_100010, 9'b111_000000, 9'b111_000010, 9'b111_011001,
        9'b111_011011, 9'b111_010000, 9'b111_010010, 9'b100_000000,
        9'b101_000000, 9'b110_000000, 9'b001_000000, 9'b010_000000,
        9'b111_111111, 9'b011_000000, 9'b111_000001
    };
    logic [3:0] t_code [0:18] = '{
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hC, 4'hD,
        4'h3, 4'h1, 4'h0, 4'h7, 4'h3, 4'h9, 4'h9, 4'h9
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh);
        bus.ALUOp       = op;
        bus.ALUFunction = fn;
        bus.A           = a;
        bus.B           = b;
        bus.shamt       = sh;
    endtask

    // Behavioural model: expected result, error flag and latency; updates HI/LO.
    task automatic model(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh, output logic [W-1:0] r, output logic e, output int lat);
        logic [63:0] p;
        r   = '0;
        e   = 1'b0;
        lat = 1;
        case (code)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = ~(a | b);
            4'h3: r = a + b;
            4'h4: r = a - b;
            4'h5: r = b << sh;
            4'h6: r = b >> sh;
            4'h7: r = b << (W/2);
            4'hA: begin
                p    = 64'(a) * 64'(b);
                m_hi = p[63:32];
                m_lo = p[31:0];
                r    = m_lo;
                lat  = W + 1;
            end
            4'hB: begin
                if (b == '0) begin
                    m_hi = a;
                    m_lo = '1;
                end else begin
                    m_hi = a % b;
                    m_lo = a / b;
                    lat  = W + 1;
                end
                r = m_lo;
            end
            4'hC: r = m_hi;
            4'hD: r = m_lo;
            default: e = 1'b1;
        endcase
    endtask

    // Issue one request, wait for its response and compare everything against the model.
    task automatic exec(input string tag, input logic [2:0] op, input logic [5:0] fn, input logic [3:0] code,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh);
        logic [W-1:0] er;
        logic         ee;
        int           elat;
        int           lat;
        int           low;
        model(code, a, b, sh, er, ee, elat);
        drive(op, fn, a, b, sh);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        low = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.in_ready !== 1'b1) low++;
            step();
            lat++;
        end
        check({tag, "/latency"}, lat, elat);
        check({tag, "/busy_cycles"}, low, elat - 1);
        check({tag, "/result"}, bus.result, er);
        check({tag, "/zero"}, bus.zero, (er == '0));
        check({tag, "/err"}, bus.err, ee);
        check({tag, "/hi"}, bus.hi, m_hi);
        check({tag, "/lo"}, bus.lo, m_lo);
        check({tag, "/ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           lat;
        int           idx;
        logic         seen;
        logic [5:0]   fn;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        bus.in_valid = 1'b0;
        drive(3'b000, 6'b000000, '0, '0, '0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst/out_valid", bus.out_valid, 1'b0);
        check("rst/result", bus.result, '0);
        check("rst/zero", bus.zero, 1'b0);
        check("rst/err", bus.err, 1'b0);
        check("rst/hi", bus.hi, '0);
        check("rst/lo", bus.lo, '0);
        check("rst/in_ready", bus.in_ready, 1'b1);
        reset = 1'b0;
        step();
        check("post_rst/out_valid", bus.out_valid, 1'b0);

        // Decode sweep; don't-care function fields get random values
        for (int i = 0; i < 19; i++) begin
            fn = t_sel[i][5:0];
            if (t_sel[i][8:6] != 3'b111) fn = 6'($urandom);
            drive(t_sel[i][8:6], fn, '0, '0, '0);
            #1;
            check($sformatf("decode/%0d", i), bus.ALUOperation, t_code[i]);
        end
        step();

        exec("inv_rfunc", 3'b111, 6'b111111, 4'h9, 32'h1234, 32'h5678, 5'd0);
        exec("inv_class", 3'b011, 6'b000000, 4'h9, 32'h1, 32'h1, 5'd0);

        // Directed single-cycle corners
        exec("add_ovf", 3'b111, 6'b100000, 4'h3, 32'h7FFFFFFF, 32'h1, 5'd0);
        check("add_ovf/const", bus.result, 32'h80000000);
        exec("sub_zero", 3'b111, 6'b100010, 4'h4, 32'd5, 32'd5, 5'd0);
        check("sub_zero/const", bus.zero, 1'b1);
        exec("sll31", 3'b111, 6'b000000, 4'h5, 32'h0, 32'h1, 5'd31);
        check("sll31/const", bus.result, 32'h80000000);
        exec("lui", 3'b001, 6'b101010, 4'h7, 32'h0, 32'h1234, 5'd0);
        check("lui/const", bus.result, 32'h12340000);
        step();
        check("drop/out_valid", bus.out_valid, 1'b0);
        check("drop/result_held", bus.result, 32'h12340000);

        // Multiply, then MFHI accepted in the completion cycle
        exec("multu_max", 3'b111, 6'b011001, 4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        check("multu_max/hi_const", bus.hi, 32'hFFFFFFFE);
        check("multu_max/lo_const", bus.lo, 32'h00000001);
        exec("mfhi_b2b", 3'b111, 6'b010000, 4'hC, 32'h0, 32'h0, 5'd0);
        check("mfhi_b2b/const", bus.result, 32'hFFFFFFFE);

        // Divide and divide-by-zero
        exec("divu_100_7", 3'b111, 6'b011011, 4'hB, 32'd100, 32'd7, 5'd0);
        check("divu_100_7/lo_const", bus.lo, 32'd14);
        check("divu_100_7/hi_const", bus.hi, 32'd2);
        exec("divu_by0", 3'b111, 6'b011011, 4'hB, 32'd9, 32'd0, 5'd0);
        check("divu_by0/lo_const", bus.lo, 32'hFFFFFFFF);
        check("divu_by0/hi_const", bus.hi, 32'd9);

        // Request held high during a divide, with operands changed mid-operation
        drive(3'b111, 6'b011011, 32'd100, 32'd7, 5'd0);
        bus.in_valid = 1'b1;
        step();
        drive(3'b111, 6'b100000, 32'd2, 32'd3, 5'd0);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        check("held/latency", lat, W + 1);
        check("held/quotient", bus.result, 32'd14);
        check("held/hi", bus.hi, 32'd2);
        check("held/lo", bus.lo, 32'd14);
        m_hi = 32'd2;
        m_lo = 32'd14;
        step();
        bus.in_valid = 1'b0;
        check("held/add_valid", bus.out_valid, 1'b1);
        check("held/add_result", bus.result, 32'd5);

        // Asynchronous reset in the middle of a multiply
        exec("pre_rst_add", 3'b111, 6'b100000, 4'h3, 32'h11, 32'h22, 5'd0);
        drive(3'b111, 6'b011001, 32'h12345678, 32'h9ABC, 5'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        #2;
        reset = 1'b1;
        #1;
        check("midrst/out_valid", bus.out_valid, 1'b0);
        check("midrst/result", bus.result, '0);
        check("midrst/zero", bus.zero, 1'b0);
        check("midrst/err", bus.err, 1'b0);
        check("midrst/hi", bus.hi, '0);
        check("midrst/lo", bus.lo, '0);
        check("midrst/in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        check("midrst/no_pulse", seen, 1'b0);
        exec("post_rst_add", 3'b111, 6'b100000, 4'h3, 32'd2, 32'd3, 5'd0);
        check("post_rst_add/const", bus.result, 32'd5);

        // Random operations against the model
        for (int k = 0; k < 40; k++) begin
            idx = $urandom_range(0, 18);
            fn  = t_sel[idx][5:0];
            if (t_sel[idx][8:6] != 3'b111) fn = 6'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
            exec($sformatf("rand/%0d", k), t_sel[idx][8:6], fn, t_code[idx], ra, rb, 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
